// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared state encoding, direction codes and sizing helper for deserializador4
// Purpose: common definitions imported by deserializador4 and its sub-module.
//   state_t       : ST_IDLE / ST_COLLECT / ST_PARITY
//   DIR_*         : stream bit-order encodings
//   cntWidth()    : width of a counter that must hold 0..width
package deser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PARITY  = 2'd2
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b1;
  localparam logic DIR_LSB_FIRST = 1'b0;

  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fifo_sinc.sv
// rtl/fifo_sinc.sv - parameterised synchronous FIFO with async active-low reset
// Purpose: small word buffer between the deserializer and its consumer.
// Ports:
//   CLK, RESET_L : clock, asynchronous active-low reset
//   PUSH, WR_DATA: write request and data; accepted when not full, or when
//                  full and a pop happens in the same cycle
//   POP          : read request, ignored when empty
//   RD_DATA      : head entry (0 while empty)
//   FULL, EMPTY  : occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap on their own.
module fifo_sinc #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             PUSH,
  input  logic             POP,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             FULL,
  output logic             EMPTY
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             doPush;
  logic             doPop;

  assign EMPTY   = (count == '0);
  assign FULL    = (count == CW'(DEPTH));
  assign doPop   = POP & ~EMPTY;
  // A full FIFO can still take a word if the head leaves in the same cycle.
  assign doPush  = PUSH & (~FULL | doPop);
  assign RD_DATA = EMPTY ? '0 : mem[rdPtr];

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (doPush) begin
        mem[wrPtr] <= WR_DATA;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/deserializador4.sv
// rtl/deserializador4.sv - serial-to-word deserializer with 2-entry output FIFO
// Purpose: rebuilds WIDTH-bit words from the producer's serial stream,
//   honouring the bit order latched with the first bit of each word, and
//   offers them on a valid/ready interface.
// Optional build macro: DESER_PARITY_EN (trailing even-parity bit per word,
//   adds PAR_ERR).
// Ports:
//   CLK, RESET_L     : clock, asynchronous active-low reset
//   S_IN, BIT_VLD    : serial bit and its qualifier
//   DIR              : 1 = MSB-first, 0 = LSB-first (taken with the first bit)
//   SYNC             : drop the partial word and restart
//   OUT_DATA/OUT_VLD : head-of-FIFO word and its valid
//   OUT_RDY          : consumer accepts the head word
//   OVF, CLR_OVF     : sticky overflow flag and its synchronous clear
//   BIT_CNT          : bits collected in the current partial word
//   PAR_ERR          : sticky parity error (DESER_PARITY_EN only)
module deserializador4
  import deser_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                         CLK,
  input  logic                         RESET_L,
  input  logic                         S_IN,
  input  logic                         BIT_VLD,
  input  logic                         DIR,
  input  logic                         SYNC,
  output logic [WIDTH-1:0]             OUT_DATA,
  output logic                         OUT_VLD,
  input  logic                         OUT_RDY,
  output logic                         OVF,
  input  logic                         CLR_OVF,
  output logic [cntWidth(WIDTH)-1:0]   BIT_CNT
`ifdef DESER_PARITY_EN
  ,
  output logic                         PAR_ERR
`endif
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           stateNext;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] accNext;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    bitCnt;
  logic [CW-1:0]    cntNext;
  logic             dirQ;
  logic             dirNext;
  logic             bitDir;
  logic             pushReq;
  logic [WIDTH-1:0] pushData;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             pop;
  logic             dropWord;
  logic             ovfQ;
`ifdef DESER_PARITY_EN
  logic             parSet;
  logic             parErrQ;
`endif

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state   <= ST_IDLE;
      acc     <= '0;
      bitCnt  <= '0;
      dirQ    <= DIR_MSB_FIRST;
      ovfQ    <= 1'b0;
`ifdef DESER_PARITY_EN
      parErrQ <= 1'b0;
`endif
    end else begin
      state  <= stateNext;
      acc    <= accNext;
      bitCnt <= cntNext;
      dirQ   <= dirNext;
      // A new event wins over a simultaneous clear.
      if (dropWord) begin
        ovfQ <= 1'b1;
      end else if (CLR_OVF) begin
        ovfQ <= 1'b0;
      end
`ifdef DESER_PARITY_EN
      if (parSet) begin
        parErrQ <= 1'b1;
      end else if (CLR_OVF) begin
        parErrQ <= 1'b0;
      end
`endif
    end
  end

  always_comb begin
    stateNext = state;
    accNext   = acc;
    cntNext   = bitCnt;
    dirNext   = dirQ;
    pushReq   = 1'b0;
    pushData  = acc;
`ifdef DESER_PARITY_EN
    parSet    = 1'b0;
`endif
    // The first bit of a word uses the live DIR; later bits use the latched one.
    bitDir  = (state == ST_IDLE) ? DIR : dirQ;
    shifted = (bitDir == DIR_MSB_FIRST) ? {acc[WIDTH-2:0], S_IN}
                                        : {S_IN, acc[WIDTH-1:1]};
    if (SYNC) begin
      stateNext = ST_IDLE;
      cntNext   = '0;
    end else if (BIT_VLD) begin
      case (state)
        ST_IDLE: begin
          dirNext   = DIR;
          accNext   = shifted;
          cntNext   = CW'(1);
          stateNext = ST_COLLECT;
        end
        ST_COLLECT: begin
          accNext = shifted;
          if (bitCnt == LAST_BIT) begin
`ifdef DESER_PARITY_EN
            cntNext   = CW'(WIDTH);
            stateNext = ST_PARITY;
`else
            pushReq   = 1'b1;
            pushData  = shifted;
            cntNext   = '0;
            stateNext = ST_IDLE;
`endif
          end else begin
            cntNext = bitCnt + CW'(1);
          end
        end
`ifdef DESER_PARITY_EN
        ST_PARITY: begin
          pushReq   = 1'b1;
          pushData  = acc;
          parSet    = ((^acc) != S_IN);
          cntNext   = '0;
          stateNext = ST_IDLE;
        end
`endif
        default: begin
          cntNext   = '0;
          stateNext = ST_IDLE;
        end
      endcase
    end
  end

  assign OUT_VLD  = ~fifoEmpty;
  assign pop      = OUT_VLD & OUT_RDY;
  assign dropWord = pushReq & fifoFull & ~pop;
  assign OVF      = ovfQ;
  assign BIT_CNT  = bitCnt;
`ifdef DESER_PARITY_EN
  assign PAR_ERR  = parErrQ;
`endif

  fifo_sinc #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK    (CLK),
    .RESET_L(RESET_L),
    .PUSH   (pushReq),
    .POP    (pop),
    .WR_DATA(pushData),
    .RD_DATA(OUT_DATA),
    .FULL   (fifoFull),
    .EMPTY  (fifoEmpty)
  );

endmodule

// File: tb/tb_deserializador4.sv
// tb/tb_deserializador4.sv - self-checking bench for deserializador4
module tb_deserializador4;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(WIDTH + 1);
`ifdef DESER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  logic             CLK = 1'b0;
  logic             RESET_L = 1'b0;
  logic             S_IN = 1'b0;
  logic             BIT_VLD = 1'b0;
  logic             DIR = 1'b0;
  logic             SYNC = 1'b0;
  logic             OUT_RDY = 1'b0;
  logic             CLR_OVF = 1'b0;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_VLD;
  logic             OVF;
  logic [CW-1:0]    BIT_CNT;
`ifdef DESER_PARITY_EN
  logic             PAR_ERR;
`endif

  always #5 CLK = ~CLK;

  deserializador4 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .S_IN    (S_IN),
    .BIT_VLD (BIT_VLD),
    .DIR     (DIR),
    .SYNC    (SYNC),
    .OUT_DATA(OUT_DATA),
    .OUT_VLD (OUT_VLD),
    .OUT_RDY (OUT_RDY),
    .OVF     (OVF),
    .CLR_OVF (CLR_OVF),
    .BIT_CNT (BIT_CNT)
`ifdef DESER_PARITY_EN
    ,
    .PAR_ERR (PAR_ERR)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bits gathered so far, buffered words, sticky flags.
  bit mBits[$];
  int mQ[$];
  bit mDir;
  bit mOvf;
  bit mPerr;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mBits.delete();
    mQ.delete();
    mDir  = 1'b1;
    mOvf  = 1'b0;
    mPerr = 1'b0;
  endtask

  task automatic modelEdge();
    bit pop;
    bit full;
    bit done;
    bit ovfSet;
    bit perrSet;
    int word;
    pop     = (mQ.size() > 0) && OUT_RDY;
    full    = (mQ.size() == DEPTH);
    done    = 1'b0;
    ovfSet  = 1'b0;
    perrSet = 1'b0;
    word    = 0;
    if (SYNC) begin
      mBits.delete();
    end else if (BIT_VLD) begin
      if (mBits.size() == 0) mDir = DIR;
      mBits.push_back(S_IN);
      if (mBits.size() == NBITS) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (mBits[i]) word += 1 << (mDir ? (WIDTH - 1 - i) : i);
        end
        if (NBITS > WIDTH) perrSet = (($countones(word) % 2) != int'(mBits[NBITS-1]));
        done = 1'b1;
        mBits.delete();
      end
    end
    if (pop) void'(mQ.pop_front());
    if (done) begin
      if (full && !pop) ovfSet = 1'b1;
      else mQ.push_back(word);
    end
    if (ovfSet) mOvf = 1'b1;
    else if (CLR_OVF) mOvf = 1'b0;
    if (perrSet) mPerr = 1'b1;
    else if (CLR_OVF) mPerr = 1'b0;
  endtask

  task automatic compareAll();
    check("out_vld", int'(OUT_VLD), int'(mQ.size() > 0));
    if (mQ.size() > 0) check("out_data", int'(OUT_DATA), mQ[0]);
    check("ovf", int'(OVF), int'(mOvf));
    check("bit_cnt", int'(BIT_CNT), mBits.size());
`ifdef DESER_PARITY_EN
    check("par_err", int'(PAR_ERR), int'(mPerr));
`endif
  endtask

  task automatic step(input bit vld, input bit sin, input bit dir,
                      input bit sync, input bit rdy, input bit clr);
    BIT_VLD = vld;
    S_IN    = sin;
    DIR     = dir;
    SYNC    = sync;
    OUT_RDY = rdy;
    CLR_OVF = clr;
    @(posedge CLK);
    modelEdge();
    #1;
    compareAll();
  endtask

  // Sends one word in the requested order; rdyLast applies to the final bit
  // (the parity bit when parity is built in), flip corrupts the parity bit.
  task automatic sendWord(input int w, input bit dir, input bit rdyBody,
                          input bit rdyLast, input bit flip, input int gap);
    bit b;
    bit par;
    par = bit'($countones(w[WIDTH-1:0]) % 2) ^ flip;
    for (int i = 0; i < NBITS; i++) begin
      if (i < WIDTH) b = dir ? w[WIDTH-1-i] : w[i];
      else b = par;
      step(1'b1, b, dir, 1'b0, (i == NBITS - 1) ? rdyLast : rdyBody, 1'b0);
      if (i != NBITS - 1) begin
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, ~dir, 1'b0, rdyBody, 1'b0);
      end
    end
  endtask

  task automatic applyReset();
    BIT_VLD = 1'b0;
    SYNC    = 1'b0;
    CLR_OVF = 1'b0;
    OUT_RDY = 1'b0;
    RESET_L = 1'b0;
    #2;
    modelReset();
    check("rst_vld", int'(OUT_VLD), 0);
    check("rst_data", int'(OUT_DATA), 0);
    check("rst_ovf", int'(OVF), 0);
    check("rst_cnt", int'(BIT_CNT), 0);
    @(posedge CLK);
    #1;
    RESET_L = 1'b1;
    compareAll();
  endtask

  initial begin
    applyReset();

    // MSB-first 1,0,1,1 back to back
    sendWord(4'hB, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("tp1_vld", int'(OUT_VLD), 1);
    check("tp1_data", int'(OUT_DATA), 4'hB);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("tp1_pulse", int'(OUT_VLD), 0);

    // LSB-first 1,0,1,1 with two idle cycles between bits
    sendWord(4'hD, 1'b0, 1'b1, 1'b1, 1'b0, 2);
    check("tp2_data", int'(OUT_DATA), 4'hD);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overflow with consumer stalled
    sendWord(4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    sendWord(4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    sendWord(4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("tp3_ovf", int'(OVF), 1);
    check("tp3_head", int'(OUT_DATA), 4'hA);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("tp3_pop1", int'(OUT_DATA), 4'h5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("tp3_empty", int'(OUT_VLD), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("tp3_clr", int'(OVF), 0);

    // Full FIFO, last bit lands with a pop
    sendWord(4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    sendWord(4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    sendWord(4'h6, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    check("tp4_ovf", int'(OVF), 0);
    check("tp4_head", int'(OUT_DATA), 4'h2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("tp4_third", int'(OUT_DATA), 4'h6);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("tp4_empty", int'(OUT_VLD), 0);

    // SYNC after two bits, then a clean word
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("tp5_sync_cnt", int'(BIT_CNT), 0);
    sendWord(4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("tp5_data", int'(OUT_DATA), 4'h3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("tp5_single", int'(OUT_VLD), 0);

    // Reset with full FIFO, OVF set and a partial word
    sendWord(4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    sendWord(4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    sendWord(4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyReset();

`ifdef DESER_PARITY_EN
    sendWord(4'h7, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    check("par_ok_data", int'(OUT_DATA), 4'h7);
    check("par_ok_err", int'(PAR_ERR), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    sendWord(4'h7, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    check("par_bad_data", int'(OUT_DATA), 4'h7);
    check("par_bad_err", int'(PAR_ERR), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("par_clr", int'(PAR_ERR), 0);
`endif

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 9) < 6, 1'($urandom), 1'($urandom),
           $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/deserializador4.md
Name: deserializador4

Overview:
- Downstream stage of the 4-bit universal shift register; consumes its serial output S_OUT bit by bit.
- Reassembles the stream into WIDTH-bit words, honouring the shift direction (DIR) used by the producer.
- Buffers completed words in a 2-entry FIFO and presents them on a valid/ready interface to the next consumer.
- Flags overflow when a word completes with no buffer space.

Parameters:
- WIDTH, 4, bits per assembled word (legal range 2..16).
- DEPTH, 2, output FIFO entries (power of two; 2 is the supported default).

Ports:
- CLK  input  1  single clock; all state changes on rising edge.
- RESET_L  input  1  asynchronous, active-low reset.
- S_IN  input  1  serial data bit (connects to producer S_OUT).
- BIT_VLD  input  1  S_IN is valid this cycle (connects to producer ENB, delayed one cycle to match S_OUT register).
- DIR  input  1  1 = stream is MSB-first, 0 = LSB-first; sampled with first bit of each word.
- SYNC  input  1  discard partial word, restart bit count.
- OUT_DATA  output  WIDTH  head-of-FIFO word.
- OUT_VLD  output  1  OUT_DATA is valid.
- OUT_RDY  input  1  consumer accepts word when OUT_VLD & OUT_RDY.
- OVF  output  1  sticky overflow flag.
- CLR_OVF  input  1  synchronous clear of OVF.
- BIT_CNT  output  clog2(WIDTH+1)  bits collected in current partial word (debug).

Behaviour:
- Reset (RESET_L=0, async): shift accumulator=0, BIT_CNT=0, FIFO empty, OUT_VLD=0, OUT_DATA=0, OVF=0, latched direction=1. Reset mid-word discards the partial word; reset with words buffered discards them.
- FSM, 2 states:
  - IDLE (BIT_CNT=0): on BIT_VLD, latch DIR into dir_q, store bit, go to COLLECT with BIT_CNT=1.
  - COLLECT: each BIT_VLD stores one bit and increments BIT_CNT. BIT_VLD=0 holds state (gaps allowed).
  - On the WIDTH-th bit: push word, BIT_CNT returns to 0, go to IDLE.
- Bit placement:
  - dir_q=1: accumulator shifts left, new bit enters bit 0, so the first bit ends at MSB.
  - dir_q=0: shifts right, new bit enters bit WIDTH-1, so the first bit ends at bit 0.
  - DIR changes mid-word are ignored until the next word.
- SYNC=1: BIT_CNT=0, go to IDLE, current BIT_VLD bit ignored. SYNC has priority over word completion. FIFO is untouched.
- Latency: word is on OUT_DATA with OUT_VLD=1 in the cycle after its last bit is sampled (if the FIFO was empty).
- FIFO:
  - Pop on OUT_VLD & OUT_RDY.
  - OUT_DATA/OUT_VLD are driven from the head entry.
  - OUT_DATA holds stable while OUT_VLD=1 and OUT_RDY=0.
- Full and simultaneous events:
  - Word completes with FIFO full and no pop that cycle: word dropped, OVF set next cycle, FIFO contents unchanged.
  - Word completes with FIFO full and a pop in the same cycle: push accepted, no overflow.
  - Push and pop in the same cycle with FIFO empty: not possible, since OUT_VLD=0 when empty; the push lands and OUT_VLD rises next cycle.
- OVF: stays set until CLR_OVF=1. CLR_OVF and a new overflow in the same cycle leave OVF=1.
- Pointers wrap modulo DEPTH; the count ranges 0..DEPTH.

Optional Feature:
- Macro: DESER_PARITY_EN.
- Defined:
  - Each word is followed by one even-parity bit; state PARITY is inserted after the WIDTH-th bit.
  - The word is pushed only after the parity bit arrives.
  - Adds output PAR_ERR (1 bit, sticky, cleared by CLR_OVF), set when received parity does not match the XOR of the data bits. The word is still pushed.
  - Latency becomes one bit later.
- Undefined: no PARITY state, no PAR_ERR port; behaviour as above.

Decomposition:
- Shared package deser_pkg:
  - state encoding constants ST_IDLE, ST_COLLECT, ST_PARITY.
  - DIR encodings DIR_MSB_FIRST=1, DIR_LSB_FIRST=0.
  - function computing counter width from WIDTH.
- One sub-module: fifo_sinc, a parameterised synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty and async active-low reset on CLK/RESET_L.

Test Plan (WIDTH=4):
- Reset, then DIR=1, bits 1,0,1,1 with BIT_VLD each cycle and OUT_RDY=1 -> OUT_DATA=4'b1011, OUT_VLD=1 one cycle after 4th bit, 1 cycle wide.
- DIR=0, bits 1,0,1,1 with BIT_VLD gaps of 2 cycles -> OUT_DATA=4'b1101; BIT_CNT holds during gaps.
- OUT_RDY=0, send 3 words 0xA,0x5,0xF -> FIFO holds 0xA,0x5; OVF=1 after 3rd word. Raise OUT_RDY -> pops 0xA then 0x5. CLR_OVF -> OVF=0.
- FIFO full, 4th bit of a word arrives in the same cycle as a pop -> no OVF, new word delivered third.
- After 2 bits, assert SYNC; then send 0x3 MSB-first -> only 0x3 emitted. Also RESET_L low mid-word -> all outputs 0, FIFO empty.
- With DESER_PARITY_EN, send 0x7 plus parity bit 1 -> OUT_DATA=0x7, PAR_ERR=0. Send 0x7 plus parity bit 0 -> word pushed, PAR_ERR=1.
